alu_exec_stage: RTL and testbench



---
 rtl/alu_exec_stage_if.sv | 51 +++++
 rtl/alu_exec_stage.sv | 148 ++++++++++++++
 tb/tb_alu_exec_stage.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_exec_stage_if.sv
// ---------------------------------------------------------------------------
// alu_exec_stage_if
// Bundle of the operand/function handshake and the result handshake used by
// the Y86-64 execute stage.
//   upstream  : in_valid, in_ready, alu_fun, val_a, val_b, set_cc, cond_fun,
//               flush
//   downstream: out_valid, out_ready, val_e, cond_out, cc_out
//               (+ out_err when ALU_EXEC_ERR_EN is defined)
// Modports: master = the surrounding pipeline / bench, slave = the stage.
// Optional feature macro: ALU_EXEC_ERR_EN adds out_err.
// ---------------------------------------------------------------------------
interface alu_exec_stage_if #(
  parameter int W = 64
);
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   alu_fun;
  logic [W-1:0] val_a;
  logic [W-1:0] val_b;
  logic         set_cc;
  logic [3:0]   cond_fun;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] val_e;
  logic         cond_out;
  logic [2:0]   cc_out;
`ifdef ALU_EXEC_ERR_EN
  logic         out_err;

  modport master (
    output in_valid, alu_fun, val_a, val_b, set_cc, cond_fun, flush, out_ready,
    input  in_ready, out_valid, val_e, cond_out, cc_out, out_err
  );

  modport slave (
    input  in_valid, alu_fun, val_a, val_b, set_cc, cond_fun, flush, out_ready,
    output in_ready, out_valid, val_e, cond_out, cc_out, out_err
  );
`else
  modport master (
    output in_valid, alu_fun, val_a, val_b, set_cc, cond_fun, flush, out_ready,
    input  in_ready, out_valid, val_e, cond_out, cc_out
  );

  modport slave (
    input  in_valid, alu_fun, val_a, val_b, set_cc, cond_fun, flush, out_ready,
    output in_ready, out_valid, val_e, cond_out, cc_out
  );
`endif
endinterface

// File: rtl/alu_exec_stage.sv
// ---------------------------------------------------------------------------
// alu_exec_stage
// Registered Y86-64 execute stage. Accepts one operand/function transaction
// per cycle on a valid/ready handshake, returns result, condition outcome and
// owns the condition-code register {ZF,SF,OF}.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - alu_exec_stage_if.slave (operand handshake in, result out)
// Optional feature macro: ALU_EXEC_ERR_EN adds registered out_err, high for
// an unknown alu_fun (4-15) or cond_fun (7-15).
// ---------------------------------------------------------------------------
module alu_exec_stage #(
  parameter int W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_exec_stage_if.slave   bus
);

  localparam logic [2:0] CC_RESET = 3'b100;

  function automatic logic signed [W-1:0] alu_result(
    input logic [3:0]          fun,
    input logic signed [W-1:0] a,
    input logic signed [W-1:0] b
  );
    logic signed [W-1:0] t;
    case (fun)
      4'd0:    t = b + a;
      4'd1:    t = b - a;
      4'd2:    t = b & a;
      4'd3:    t = b ^ a;
      default: t = '0;
    endcase
    return t;
  endfunction

  // Returns {ZF,SF,OF}; overflow only meaningful for add/sub.
  function automatic logic [2:0] alu_flags(
    input logic [3:0]          fun,
    input logic signed [W-1:0] a,
    input logic signed [W-1:0] b,
    input logic signed [W-1:0] t
  );
    logic zf;
    logic sf;
    logic of;
    zf = (t == '0);
    sf = t[W-1];
    case (fun)
      4'd0:    of = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
      4'd1:    of = (a[W-1] != b[W-1]) && (t[W-1] != b[W-1]);
      default: of = 1'b0;
    endcase
    return {zf, sf, of};
  endfunction

  function automatic logic cond_eval(
    input logic [2:0] cc,
    input logic [3:0] cf
  );
    logic zf;
    logic lt;
    logic c;
    zf = cc[2];
    lt = cc[1] ^ cc[0];
    case (cf)
      4'd0:    c = 1'b1;
      4'd1:    c = lt | zf;
      4'd2:    c = lt;
      4'd3:    c = zf;
      4'd4:    c = !zf;
      4'd5:    c = !lt;
      4'd6:    c = !lt && !zf;
      default: c = 1'b0;
    endcase
    return c;
  endfunction

  logic signed [W-1:0] w_a_p0;
  logic signed [W-1:0] w_b_p0;
  logic signed [W-1:0] w_res_p0;
  logic [2:0]          w_flags_p0;
  logic                w_cond_p0;
  logic                w_fun_ok_p0;
  logic                w_in_ready;
  logic                w_accept;

  logic                r_vld_p1;
  logic signed [W-1:0] r_val_e_p1;
  logic                r_cond_p1;
  logic [2:0]          r_cc;
`ifdef ALU_EXEC_ERR_EN
  logic                r_err_p1;
`endif

  // ---- stage p0: combinational execute on the offered transaction ----
  assign w_a_p0      = bus.val_a;
  assign w_b_p0      = bus.val_b;
  assign w_res_p0    = alu_result(bus.alu_fun, w_a_p0, w_b_p0);
  assign w_flags_p0  = alu_flags(bus.alu_fun, w_a_p0, w_b_p0, w_res_p0);
  // Condition uses the CC as it stands before this op can update it.
  assign w_cond_p0   = cond_eval(r_cc, bus.cond_fun);
  assign w_fun_ok_p0 = (bus.alu_fun < 4'd4);

  // Output slot is free when empty or being drained this cycle; flush blocks
  // any accept so a flushed cycle never sneaks a new op in.
  assign w_in_ready = !bus.flush && (!r_vld_p1 || bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;

  // ---- stage p1: result register and architectural CC ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1   <= 1'b0;
      r_val_e_p1 <= '0;
      r_cond_p1  <= 1'b0;
      r_cc       <= CC_RESET;
`ifdef ALU_EXEC_ERR_EN
      r_err_p1   <= 1'b0;
`endif
    end else if (bus.flush) begin
      r_vld_p1 <= 1'b0;
    end else if (w_accept) begin
      r_vld_p1   <= 1'b1;
      r_val_e_p1 <= w_res_p0;
      r_cond_p1  <= w_cond_p0;
`ifdef ALU_EXEC_ERR_EN
      r_err_p1   <= !w_fun_ok_p0 || (bus.cond_fun > 4'd6);
`endif
      if (bus.set_cc && w_fun_ok_p0) begin
        r_cc <= w_flags_p0;
      end
    end else if (bus.out_ready) begin
      r_vld_p1 <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_vld_p1;
  assign bus.val_e     = r_val_e_p1;
  assign bus.cond_out  = r_cond_p1;
  assign bus.cc_out    = r_cc;
`ifdef ALU_EXEC_ERR_EN
  assign bus.out_err   = r_err_p1;
`endif

endmodule

// File: tb/tb_alu_exec_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_exec_stage
// Self-checking bench for alu_exec_stage: directed scenarios followed by
// randomized traffic, compared cycle by cycle against a behavioural model.
// ---------------------------------------------------------------------------
module tb_alu_exec_stage;

  localparam int W = 64;

  logic clk;
  logic rst_n;

  alu_exec_stage_if #(.W(W)) bus ();

  alu_exec_stage #(.W(W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_err;
  int n_delivered;

  // Model state: what the stage is expected to present.
  bit           m_valid;
  logic [W-1:0] m_val;
  bit           m_cond;
  bit           m_zf, m_sf, m_of;
  bit           m_err;

  always @(posedge clk)
    if (rst_n && bus.out_valid && bus.out_ready) n_delivered <= n_delivered + 1;

  task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_val = '0; m_cond = 0;
    m_zf = 1; m_sf = 0; m_of = 0; m_err = 0;
  endtask

  function automatic bit model_cond(input logic [3:0] cf);
    bit less;
    less = (m_sf != m_of);
    case (cf)
      0: return 1;
      1: return less || m_zf;
      2: return less;
      3: return m_zf;
      4: return !m_zf;
      5: return !less;
      6: return !less && !m_zf;
      default: return 0;
    endcase
  endfunction

  task automatic drive(input bit v, input logic [3:0] fun, input logic [W-1:0] a,
                       input logic [W-1:0] b, input bit sc, input logic [3:0] cf,
                       input bit fl, input bit ordy);
    bus.in_valid = v; bus.alu_fun = fun; bus.val_a = a; bus.val_b = b;
    bus.set_cc = sc; bus.cond_fun = cf; bus.flush = fl; bus.out_ready = ordy;
  endtask

  task automatic check_outputs(input string tag);
    check_val({tag, ".out_valid"}, W'(bus.out_valid), W'(m_valid));
    check_val({tag, ".val_e"}, bus.val_e, m_val);
    check_val({tag, ".cond_out"}, W'(bus.cond_out), W'(m_cond));
    check_val({tag, ".cc_out"}, W'(bus.cc_out), W'({m_zf, m_sf, m_of}));
`ifdef ALU_EXEC_ERR_EN
    check_val({tag, ".out_err"}, W'(bus.out_err), W'(m_err));
`endif
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic cycle(input string tag, output bit acc);
    bit exp_rdy;
    logic [W-1:0] a, b, t;
    #1;
    exp_rdy = !bus.flush && (!m_valid || bus.out_ready);
    check_val({tag, ".in_ready"}, W'(bus.in_ready), W'(exp_rdy));
    acc = bus.in_valid && exp_rdy;
    a = bus.val_a; b = bus.val_b;
    @(posedge clk);
    if (bus.flush) begin
      m_valid = 0;
    end else if (acc) begin
      case (bus.alu_fun)
        0: t = b + a;
        1: t = b - a;
        2: t = b & a;
        3: t = b ^ a;
        default: t = '0;
      endcase
      m_valid = 1;
      m_val   = t;
      m_cond  = model_cond(bus.cond_fun);
      m_err   = (bus.alu_fun > 3) || (bus.cond_fun > 6);
      if (bus.set_cc && bus.alu_fun <= 3) begin
        m_zf = (t == 0);
        m_sf = t[W-1];
        if (bus.alu_fun == 0)      m_of = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
        else if (bus.alu_fun == 1) m_of = (a[W-1] != b[W-1]) && (t[W-1] != b[W-1]);
        else                       m_of = 0;
      end
    end else if (bus.out_ready) begin
      m_valid = 0;
    end
    #1;
    check_outputs(tag);
    @(negedge clk);
  endtask

  function automatic logic [W-1:0] rnd_operand();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return {1'b0, {(W-1){1'b1}}};
      2: return {1'b1, {(W-1){1'b0}}};
      3: return '1;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    bit acc;
    int issued;
    n_chk = 0; n_err = 0; n_delivered = 0;
    drive(0, 0, '0, '0, 0, 0, 0, 1);
    rst_n = 0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1;

    // Add overflow, then conditions read the new CC {0,1,1}.
    drive(1, 0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1, 0, 0, 1);
    cycle("add_ovf", acc);
    check_val("add_ovf.result", bus.val_e, 64'h8000_0000_0000_0000);
    check_val("add_ovf.cc", W'(bus.cc_out), W'(3'b011));
    drive(1, 2, 64'h5, 64'h6, 0, 2, 0, 1);
    cycle("cond_l", acc);
    check_val("cond_l.value", W'(bus.cond_out), W'(0));
    drive(1, 2, 64'h5, 64'h6, 0, 1, 0, 1);
    cycle("cond_le", acc);

    // Sub to zero, then e / ne.
    drive(1, 1, 64'h2A, 64'h2A, 1, 0, 0, 1);
    cycle("sub_zero", acc);
    check_val("sub_zero.cc", W'(bus.cc_out), W'(3'b100));
    drive(1, 3, 64'h1, 64'h2, 0, 3, 0, 1);
    cycle("cond_e", acc);
    check_val("cond_e.value", W'(bus.cond_out), W'(1));
    drive(1, 3, 64'h1, 64'h2, 0, 4, 0, 1);
    cycle("cond_ne", acc);

    // Backpressure: three xor ops, out_ready low for four cycles.
    drive(0, 0, '0, '0, 0, 0, 0, 1);
    cycle("drain", acc);
    n_delivered = 0;
    issued = 0;
    for (int i = 0; i < 12; i++) begin
      drive(issued < 3, 3, 64'hF0, 64'hFF, 0, 0, 0, i >= 4);
      cycle("bp", acc);
      if (acc) issued++;
      if (i >= 1 && i < 4) check_val("bp.held", bus.val_e, 64'h0F);
    end
    check_val("bp.issued", W'(issued), W'(3));
    check_val("bp.delivered", W'(n_delivered), W'(3));

    // Flush with a held result and a new op offered.
    drive(1, 0, 64'h3, 64'h4, 1, 0, 0, 0);
    cycle("fl_setup", acc);
    drive(1, 1, 64'h9, 64'h1, 1, 0, 1, 1);
    cycle("flush", acc);
    check_val("flush.dropped", W'(bus.out_valid), W'(0));

    // Invalid function code.
    drive(1, 5, 64'h1, 64'h1, 1, 0, 0, 1);
    cycle("bad_fun", acc);
    check_val("bad_fun.val_e", bus.val_e, '0);

    // Asynchronous reset with a result held.
    drive(1, 0, 64'h10, 64'h20, 1, 0, 0, 0);
    cycle("rst_setup", acc);
    #2;
    rst_n = 0;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(negedge clk);
    rst_n = 1;

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0,
            ($urandom_range(0, 9) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3)),
            rnd_operand(), rnd_operand(), $urandom_range(0, 1) == 1,
            4'($urandom_range(0, 15)), $urandom_range(0, 9) == 0,
            $urandom_range(0, 9) < 7);
      cycle("rand", acc);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
